// File: rtl/cplink_slave_seq.sv
// Slave-side sequencer: arbitrates sd[7:0] between draining host->slave FIFO and loading slave->host FIFO.
// Latency: flag seen 2 cycles after edge; byte period 2+PULSE_CYC+RECOV_CYC, +TURN_CYC on direction change.
// Backpressure: full rx buffer blocks reads only; empty tx buffer blocks writes only; tx_ready = ~tx_full.
module cplink_slave_seq #(
    parameter int PULSE_CYC = 3,
    parameter int TURN_CYC  = 2,
    parameter int RECOV_CYC = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       fifo_slave_dor,
    input  logic       fifo_slave_dir,
    input  logic [7:0] sd_in,
    output logic [7:0] sd_out,
    output logic       sd_oe,
    output logic       slave_fifo_wnr,
    output logic       slave_fifo_si,
    output logic       slave_fifo_sob,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    typedef enum logic [2:0] {IDLE, TURN, RD_SAMPLE, RD_SOB, WR_SETUP, WR_SI, RECOV} state_t;

    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] TURN_LD  = 4'(TURN_CYC - 1);
    localparam logic [3:0] RECOV_LD = 4'(RECOV_CYC - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       wnr, wnr_nxt;
    logic       oe, oe_nxt;
    logic [7:0] sd_out_q, sd_out_nxt;
    logic       si, si_nxt;
    logic       sob, sob_nxt;
    logic       grant, grant_nxt;
    logic       last_grant, last_grant_nxt;
    logic       rx_full, tx_full;
    logic [7:0] rx_dat, tx_buf;
    logic       dor_meta, dor_s, dir_meta, dir_s;
    logic       rd_req, wr_req, pick_wr;
    logic       rx_capture, tx_done;

    assign rd_req = dor_s & ~rx_full;
    assign wr_req = dir_s & tx_full;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        wnr_nxt        = wnr;
        oe_nxt         = oe;
        sd_out_nxt     = sd_out_q;
        si_nxt         = si;
        sob_nxt        = sob;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        pick_wr        = 1'b0;
        rx_capture     = 1'b0;
        tx_done        = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req || wr_req) begin
                    // On a tie serve whichever direction did not go last.
                    pick_wr        = wr_req && (!rd_req || last_grant == GRANT_RD);
                    grant_nxt      = pick_wr;
                    last_grant_nxt = pick_wr;
                    if (pick_wr) begin
                        if (wnr) begin
                            state_nxt  = WR_SETUP;
                            oe_nxt     = 1'b1;
                            sd_out_nxt = tx_buf;
                        end else begin
                            wnr_nxt   = 1'b1;
                            state_nxt = TURN;
                            cnt_nxt   = TURN_LD;
                        end
                    end else begin
                        if (!wnr) begin
                            state_nxt = RD_SAMPLE;
                        end else begin
                            wnr_nxt   = 1'b0;
                            oe_nxt    = 1'b0;
                            state_nxt = TURN;
                            cnt_nxt   = TURN_LD;
                        end
                    end
                end
            end
            TURN: begin
                if (cnt == 4'd0) begin
                    if (grant == GRANT_WR) begin
                        state_nxt  = WR_SETUP;
                        oe_nxt     = 1'b1;
                        sd_out_nxt = tx_buf;
                    end else begin
                        state_nxt = RD_SAMPLE;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RD_SAMPLE: begin
                rx_capture = 1'b1;
                sob_nxt    = 1'b0;
                state_nxt  = RD_SOB;
                cnt_nxt    = PULSE_LD;
            end
            RD_SOB: begin
                if (cnt == 4'd0) begin
                    sob_nxt   = 1'b1;
                    state_nxt = RECOV;
                    cnt_nxt   = RECOV_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WR_SETUP: begin
                si_nxt    = 1'b1;
                state_nxt = WR_SI;
                cnt_nxt   = PULSE_LD;
            end
            WR_SI: begin
                if (cnt == 4'd0) begin
                    si_nxt    = 1'b0;
                    tx_done   = 1'b1;
                    state_nxt = RECOV;
                    cnt_nxt   = RECOV_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RECOV: begin
                // Flags are stale here: the FIFO flag drop still has to cross the synchroniser.
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wnr        <= 1'b0;
            oe         <= 1'b0;
            sd_out_q   <= 8'h00;
            si         <= 1'b0;
            sob        <= 1'b1;
            grant      <= GRANT_RD;
            last_grant <= GRANT_WR;
            rx_full    <= 1'b0;
            tx_full    <= 1'b0;
            rx_dat     <= 8'h00;
            tx_buf     <= 8'h00;
            dor_meta   <= 1'b0;
            dor_s      <= 1'b0;
            dir_meta   <= 1'b0;
            dir_s      <= 1'b0;
        end else begin
            dor_meta   <= fifo_slave_dor;
            dor_s      <= dor_meta;
            dir_meta   <= fifo_slave_dir;
            dir_s      <= dir_meta;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wnr        <= wnr_nxt;
            oe         <= oe_nxt;
            sd_out_q   <= sd_out_nxt;
            si         <= si_nxt;
            sob        <= sob_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            if (rx_capture) begin
                rx_dat  <= sd_in;
                rx_full <= 1'b1;
            end else if (rx_full && rx_ready) begin
                rx_full <= 1'b0;
            end
            if (tx_done) begin
                tx_full <= 1'b0;
            end else if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    assign sd_out         = sd_out_q;
    assign sd_oe          = oe;
    assign slave_fifo_wnr = wnr;
    assign slave_fifo_si  = si;
    assign slave_fifo_sob = sob;
    assign rx_data        = rx_dat;
    assign rx_valid       = rx_full;
    assign tx_ready       = ~tx_full;

endmodule
